rotacao_inversa_seq: RTL and testbench

Sequential inverse circular shifter. It takes a word that was circularly rotated by the combinational rotator (direction `controle`, amount `rotacoes`) and recovers the original operand. It rotates one bit position per clock in the opposite direction, under a start/busy/done handshake. It sits downstream of the rotator, so the rotate/de-rotate pair can be checked end to end.

---
 rtl/rotacao_inversa_seq.sv | 153 +++++++++++++++
 tb/tb_rotacao_inversa_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rotacao_inversa_seq.sv
// rotacao_inversa_seq
// Sequential inverse circular shifter. It takes a word that the combinational
// rotator produced (direction `controle`, amount `rotacoes`) and restores the
// original operand. It undoes the rotation one bit position per clock, under a
// start/busy/done handshake.
//
// Optional build macro: ROT_MOD_EN
//   When it is defined, the step counter loads rotacoes mod WIDTH, taken from
//   the low bits, so WIDTH must be a power of two. Results are the same as
//   without the macro, and latency becomes (N mod WIDTH)+1.
//   When it is undefined, the full N single-bit steps are performed.
module rotacao_inversa_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] operando,
  input  logic             controle,
  input  logic [CNT_W-1:0] rotacoes,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] saida
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Undo a right rotation: rotate left by one position.
  function automatic logic [WIDTH-1:0] undo_left1(input logic [WIDTH-1:0] w);
    return {w[WIDTH-2:0], w[WIDTH-1]};
  endfunction

  // Undo a left rotation: rotate right by one position.
  function automatic logic [WIDTH-1:0] undo_right1(input logic [WIDTH-1:0] w);
    return {w[0], w[WIDTH-1:1]};
  endfunction

  // One undo step. dir=0 means the original rotation was to the right.
  function automatic logic [WIDTH-1:0] undo_step(input logic [WIDTH-1:0] w,
                                                 input logic             dir);
    logic [WIDTH-1:0] r;
    if (dir == 1'b0) begin
      r = undo_left1(w);
    end else begin
      r = undo_right1(w);
    end
    return r;
  endfunction

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] work_r;
  logic [WIDTH-1:0] work_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             dir_r;
  logic             dir_next_s;
  logic [WIDTH-1:0] saida_r;
  logic [WIDTH-1:0] saida_next_s;
  logic             busy_r;
  logic             done_r;
  logic [CNT_W-1:0] load_cnt_s;
  logic [WIDTH-1:0] step_s;

`ifdef ROT_MOD_EN
  // A full turn is a no-op, so only the residue modulo WIDTH has to be walked.
  assign load_cnt_s = rotacoes & CNT_W'(WIDTH - 1);
`else
  // Every requested step is walked, even past a full turn.
  assign load_cnt_s = rotacoes;
`endif

  assign step_s = undo_step(work_r, dir_r);

  // Next-state, datapath and result selection for the shift sequencer.
  always_comb begin
    state_next_s = state_r;
    work_next_s  = work_r;
    cnt_next_s   = cnt_r;
    dir_next_s   = dir_r;
    saida_next_s = saida_r;
    case (state_r)
      ST_IDLE: begin
        if (start == 1'b1) begin
          work_next_s = operando;
          cnt_next_s  = load_cnt_s;
          dir_next_s  = controle;
          if (load_cnt_s == {CNT_W{1'b0}}) begin
            // Nothing to undo: the operand itself is the result.
            state_next_s = ST_DONE;
            saida_next_s = operando;
          end else begin
            state_next_s = ST_SHIFT;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        work_next_s = step_s;
        cnt_next_s  = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          // The last step goes straight into the result register.
          state_next_s = ST_DONE;
          saida_next_s = step_s;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
        work_next_s  = {WIDTH{1'b0}};
        cnt_next_s   = {CNT_W{1'b0}};
        dir_next_s   = 1'b0;
      end
    endcase
  end

  // State, datapath and registered handshake outputs, with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      work_r  <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      dir_r   <= 1'b0;
      saida_r <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      work_r  <= work_next_s;
      cnt_r   <= cnt_next_s;
      dir_r   <= dir_next_s;
      saida_r <= saida_next_s;
      // The flags are decoded from the next state so they line up with it.
      busy_r  <= (state_next_s != ST_IDLE);
      done_r  <= (state_next_s == ST_DONE);
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign saida = saida_r;

endmodule

// File: tb/tb_rotacao_inversa_seq.sv
// Self-checking bench for rotacao_inversa_seq (WIDTH=4, CNT_W=3).
// Expected results come from an independent rotation model. They are queued at
// acceptance and compared when the design raises done.
module tb_rotacao_inversa_seq;

  localparam int W = 4;
  localparam int C = 3;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] operando;
  logic         controle;
  logic [C-1:0] rotacoes;
  logic         busy;
  logic         done;
  logic [W-1:0] saida;

  int checks;
  int failures;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
  } exp_t;

  exp_t sb[$];

  rotacao_inversa_seq #(.WIDTH(W), .CNT_W(C)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .operando (operando),
    .controle (controle),
    .rotacoes (rotacoes),
    .busy     (busy),
    .done     (done),
    .saida    (saida)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Original operand: undo a rotation of n in direction ctl.
  function automatic logic [W-1:0] model(input logic [W-1:0] op, input logic ctl, input int n);
    logic [W-1:0] r;
    int m;
    m = n % W;
    for (int i = 0; i < W; i++) begin
      if (ctl == 1'b0) r[i] = op[(i - m + W) % W];
      else             r[i] = op[(i + m) % W];
    end
    return r;
  endfunction

  function automatic int lat_of(input int n);
`ifdef ROT_MOD_EN
    return (n % W) + 1;
`else
    return n + 1;
`endif
  endfunction

  task automatic push_exp(input logic [W-1:0] op, input logic ctl, input int n);
    exp_t e;
    e.res = model(op, ctl, n);
    e.lat = lat_of(n);
    sb.push_back(e);
  endtask

  // Called #1 after the acceptance edge; waits for done and scores it.
  task automatic wait_done(input string tag, input bit poke);
    int cyc;
    int bcnt;
    bit got;
    exp_t e;
    cyc = 0;
    bcnt = 0;
    got = 1'b0;
    for (int t = 0; t < 40; t++) begin
      cyc++;
      if (busy === 1'b1) bcnt++;
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (poke && cyc == 1) begin
        start = 1'b1;
        operando = W'($urandom);
        controle = 1'($urandom);
        rotacoes = C'($urandom);
      end
      if (poke && cyc == 2) start = 1'b0;
      @(posedge clk);
      #1;
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    if (!got) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({tag, "_saida"}, 32'(saida), 32'(e.res));
    chk({tag, "_lat"}, 32'(cyc), 32'(e.lat));
    chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(e.lat));
    @(posedge clk);
    #1;
    chk({tag, "_done_drop"}, 32'(done), 32'd0);
    chk({tag, "_busy_drop"}, 32'(busy), 32'd0);
    chk({tag, "_saida_hold"}, 32'(saida), 32'(e.res));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] op, input logic ctl,
                        input int n, input bit poke);
    @(negedge clk);
    operando = op;
    controle = ctl;
    rotacoes = C'(n);
    start = 1'b1;
    @(posedge clk);
    push_exp(op, ctl, n);
    #1;
    start = 1'b0;
    operando = W'($urandom);
    controle = 1'($urandom);
    rotacoes = C'($urandom);
    wait_done(tag, poke);
  endtask

  initial begin
    bit saw_done;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b0;
    operando = '0;
    controle = 1'b0;
    rotacoes = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_saida", 32'(saida), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("t1", 4'b1001, 1'b0, 2, 1'b0);
    run_op("t2", 4'b0111, 1'b1, 3, 1'b0);
    run_op("t3", 4'b0111, 1'b1, 7, 1'b0);
    run_op("t4_n0", 4'b1010, 1'b0, 0, 1'b0);
    run_op("t5_poke", 4'b1100, 1'b0, 3, 1'b1);

    // start held high from the first request through its DONE cycle
    @(negedge clk);
    operando = 4'b0111;
    controle = 1'b1;
    rotacoes = 3'd3;
    start = 1'b1;
    @(posedge clk);
    push_exp(4'b0111, 1'b1, 3);
    #1;
    operando = 4'b1001;
    controle = 1'b0;
    rotacoes = 3'd2;
    wait_done("held_a", 1'b0);
    @(posedge clk);
    push_exp(4'b1001, 1'b0, 2);
    #1;
    start = 1'b0;
    chk("held_accept", 32'(busy), 32'd1);
    wait_done("held_b", 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] op;
      logic ctl;
      int n;
      op = W'($urandom);
      ctl = 1'($urandom_range(0, 1));
      n = $urandom_range(0, 7);
      run_op($sformatf("rnd%0d", i), op, ctl, n, n >= 2);
    end

    // reset two cycles into an N=3 operation
    @(negedge clk);
    operando = 4'b0110;
    controle = 1'b0;
    rotacoes = 3'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_saida", 32'(saida), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    chk("no_resume", 32'(saw_done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
